// File: rtl/silife_pkg.sv
// ============================================================================
// Module      : silife_pkg
// Description : Shared constants and loader state encoding for the SiLife grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package silife_pkg;

    localparam int GRID_WIDTH    = 8;
    localparam int GRID_HEIGHT   = 32;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ROW_LSB   = 0;
    localparam int CMD_ROW_MSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/silife_sync2.sv
// ============================================================================
// Module      : silife_sync2
// Description : Two-flop synchronizer with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module silife_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/silife_spi_loader.sv
// ============================================================================
// Module      : silife_spi_loader
// Description : SPI-slave row loader for the 8x32 grid; optional readback is
//               built when SILIFE_LOADER_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module silife_spi_loader #(
    parameter int GRID_WIDTH  = silife_pkg::GRID_WIDTH,
    parameter int GRID_HEIGHT = silife_pkg::GRID_HEIGHT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_spi_cs_n,
    input  logic                           i_spi_sck,
    input  logic                           i_spi_mosi,
    output logic                           o_spi_miso,
    input  logic [GRID_WIDTH-1:0]          i_cells,
    output logic [$clog2(GRID_HEIGHT)-1:0] o_row_select,
    output logic [GRID_WIDTH-1:0]          o_set_cells,
    output logic [GRID_WIDTH-1:0]          o_clear_cells,
    output logic                           o_hold
);

    import silife_pkg::*;

    localparam int ROW_W = $clog2(GRID_HEIGHT);
    localparam int BIT_W = $clog2(GRID_WIDTH);

    logic w_cs_n_s;
    logic w_sck_s;
    logic w_mosi_s;

    silife_sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_spi_cs_n),
        .o_q   (w_cs_n_s)
    );

    silife_sync2 #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_spi_sck),
        .o_q   (w_sck_s)
    );

    silife_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_spi_mosi),
        .o_q   (w_mosi_s)
    );

    logic r_cs_n_d;
    logic r_sck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n_d <= 1'b1;
            r_sck_d  <= 1'b0;
        end else begin
            r_cs_n_d <= w_cs_n_s;
            r_sck_d  <= w_sck_s;
        end
    end

    logic w_sck_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_cs_fall  = r_cs_n_d & ~w_cs_n_s;
    assign w_cs_rise  = ~r_cs_n_d & w_cs_n_s;

    loader_state_t            r_state;
    loader_state_t            w_state_next;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [GRID_WIDTH-2:0]    r_shift_in;
    logic [ROW_W-1:0]         r_row;
    logic                     r_strobe;
    logic [GRID_WIDTH-1:0]    r_set_cells;
    logic [GRID_WIDTH-1:0]    r_clear_cells;

    logic                     w_active;
    logic                     w_byte_done;
    logic [GRID_WIDTH-1:0]    w_byte;
    logic                     w_cmd_done;
    logic                     w_write_done;
    logic                     w_read_done;

    assign w_active    = (r_state != ST_IDLE);
    assign w_byte      = {r_shift_in, w_mosi_s};
    assign w_byte_done = w_active & w_sck_rise & (r_bit_cnt == BIT_W'(GRID_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completed byte is decoded in the same cycle a CS rise is seen; the
    // rise only overrides the resulting next state.
    always_comb begin
        w_state_next = r_state;
        w_cmd_done   = 1'b0;
        w_write_done = 1'b0;
        w_read_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_byte_done) begin
                    w_cmd_done   = 1'b1;
                    w_state_next = w_byte[CMD_WRITE_BIT] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_write_done = w_byte_done;
            end
            ST_READ: begin
                w_read_done = w_byte_done;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt     <= '0;
            r_shift_in    <= '0;
            r_row         <= '0;
            r_strobe      <= 1'b0;
            r_set_cells   <= '0;
            r_clear_cells <= '0;
        end else begin
            if (!w_active && w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_active && w_sck_rise) begin
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                r_shift_in <= w_byte[GRID_WIDTH-2:0];
            end

            r_strobe      <= w_write_done;
            r_set_cells   <= w_write_done ? w_byte  : '0;
            r_clear_cells <= w_write_done ? ~w_byte : '0;

            // Writes advance the row after the strobe so the address holds
            // steady across the whole write cycle.
            if (w_cmd_done) begin
                r_row <= w_byte[CMD_ROW_MSB:CMD_ROW_LSB];
            end else if (w_read_done || r_strobe) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign o_row_select  = r_row;
    assign o_set_cells   = r_set_cells;
    assign o_clear_cells = r_clear_cells;
    assign o_hold        = w_active;

`ifdef SILIFE_LOADER_READBACK_EN
    logic                  w_sck_fall;
    logic                  r_load;
    logic [GRID_WIDTH-1:0] r_shift_out;

    assign w_sck_fall = ~w_sck_s & r_sck_d;

    // The load lands one cycle after the row update, once i_cells has
    // settled on the new row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load      <= 1'b0;
            r_shift_out <= '0;
        end else begin
            r_load <= (w_cmd_done && !w_byte[CMD_WRITE_BIT]) || w_read_done;
            if (r_load) begin
                r_shift_out <= i_cells;
            end else if ((r_state == ST_READ) && w_sck_fall && (r_bit_cnt != '0)) begin
                r_shift_out <= {r_shift_out[GRID_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_spi_miso = r_shift_out[GRID_WIDTH-1];
`else
    logic w_unused_ok;

    assign w_unused_ok = &{1'b0, i_cells};
    assign o_spi_miso  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_silife_spi_loader.sv
// ============================================================================
// Module      : tb_silife_spi_loader
// Description : Self-checking bench for silife_spi_loader with a grid model
//               and a transaction-level reference of strobes and readback.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_silife_spi_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n  = 1'b1;
    logic       sck   = 1'b0;
    logic       mosi  = 1'b0;
    logic       miso;
    logic [7:0] cells;
    logic [4:0] row_sel;
    logic [7:0] set_c;
    logic [7:0] clr_c;
    logic       hold;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [4:0] row;
        logic [7:0] set;
        logic [7:0] clr;
        logic [4:0] prev_row;
    } strobe_t;

    strobe_t    got_q[$];
    strobe_t    exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] grid_mem [32];
    logic [4:0] prev_row = '0;
    logic       miso_seen = 1'b0;
    int         model_row = 0;

    always #5 clk = ~clk;

    silife_spi_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_spi_cs_n    (cs_n),
        .i_spi_sck     (sck),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .i_cells       (cells),
        .o_row_select  (row_sel),
        .o_set_cells   (set_c),
        .o_clear_cells (clr_c),
        .o_hold        (hold)
    );

    assign cells = grid_mem[row_sel];

    always @(posedge clk) begin
        if (set_c != 8'h00 || clr_c != 8'h00)
            grid_mem[row_sel] = (grid_mem[row_sel] | set_c) & ~clr_c;
    end

    always @(negedge clk) begin
        if (set_c != 8'h00 || clr_c != 8'h00)
            got_q.push_back({row_sel, set_c, clr_c, prev_row});
        if (miso === 1'b1)
            miso_seen = 1'b1;
        prev_row = row_sel;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] rx;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            clk_wait(8);
            sck   = 1'b1;
            rx[i] = miso;
            clk_wait(8);
            sck = 1'b0;
        end
        rx_q.push_back(rx);
    endtask

    task automatic spi_txn();
        rx_q.delete();
        cs_n = 1'b0;
        clk_wait(8);
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        clk_wait(8);
        cs_n = 1'b1;
        clk_wait(8);
    endtask

    // Reference: a write command names the first row; each data byte writes
    // one row and the row advances modulo 32.
    task automatic model_write();
        int r;
        r = int'(tx_q[0] & 8'h1F);
        for (int i = 1; i < tx_q.size(); i++) begin
            exp_q.push_back({5'(r), tx_q[i], ~tx_q[i], 5'(r)});
            r = (r + 1) % 32;
        end
        model_row = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({row_sel, set_c, clr_c, miso, hold} !== 23'h0)
            $display("FAIL reset_outputs got %h want 0", {row_sel, set_c, clr_c, miso, hold});
        else n_pass++;
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(6);
        n_total++;
        if ({row_sel, set_c, clr_c, miso, hold} !== 23'h0)
            $display("FAIL post_reset_idle got %h want 0", {row_sel, set_c, clr_c, miso, hold});
        else n_pass++;
    endtask

    task automatic test_write_single();
        got_q.delete(); exp_q.delete();
        tx_q = '{8'h85, 8'hA5};
        model_write();
        rx_q.delete();
        cs_n = 1'b0;
        clk_wait(2);
        n_total++;
        if (hold !== 1'b0) $display("FAIL hold_rise_early got %b want 0", hold); else n_pass++;
        clk_wait(1);
        n_total++;
        if (hold !== 1'b1) $display("FAIL hold_rise got %b want 1", hold); else n_pass++;
        clk_wait(5);
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        clk_wait(8);
        n_total++;
        if (hold !== 1'b1) $display("FAIL hold_during got %b want 1", hold); else n_pass++;
        cs_n = 1'b1;
        clk_wait(2);
        n_total++;
        if (hold !== 1'b1) $display("FAIL hold_fall_early got %b want 1", hold); else n_pass++;
        clk_wait(1);
        n_total++;
        if (hold !== 1'b0) $display("FAIL hold_fall got %b want 0", hold); else n_pass++;
        clk_wait(5);
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL single_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_write_wrap();
        got_q.delete(); exp_q.delete();
        tx_q = '{8'h9F, 8'h01, 8'h80};
        model_write();
        spi_txn();
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL wrap_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL wrap_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (row_sel !== 5'(model_row))
            $display("FAIL wrap_row got %0d want %0d", row_sel, model_row);
        else n_pass++;
    endtask

    task automatic test_abort();
        got_q.delete(); exp_q.delete();
        rx_q.delete();
        cs_n = 1'b0;
        clk_wait(8);
        spi_byte(8'h82);
        for (int i = 7; i >= 4; i--) begin
            mosi = 1'b1;
            clk_wait(8);
            sck = 1'b1;
            clk_wait(8);
            sck = 1'b0;
        end
        clk_wait(4);
        cs_n = 1'b1;
        clk_wait(8);
        n_total++;
        if (got_q.size() !== 0) $display("FAIL abort_strobe got %0d want 0", got_q.size()); else n_pass++;
        n_total++;
        if (hold !== 1'b0) $display("FAIL abort_hold got %b want 0", hold); else n_pass++;
        n_total++;
        if (row_sel !== 5'd2) $display("FAIL abort_row got %0d want 2", row_sel); else n_pass++;
        tx_q = '{8'h8A, 8'h3C};
        model_write();
        spi_txn();
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL abort_next_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL abort_next_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_writes();
        got_q.delete(); exp_q.delete();
        for (int t = 0; t < 6; t++) begin
            tx_q.delete();
            tx_q.push_back(8'($urandom_range(128, 255)));
            for (int b = 0; b < int'($urandom_range(1, 4)); b++)
                tx_q.push_back(8'($urandom));
            model_write();
            spi_txn();
            n_total++;
            if (row_sel !== 5'(model_row))
                $display("FAIL rand_row[%0d] got %0d want %0d", t, row_sel, model_row);
            else n_pass++;
        end
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL rand_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    // CS rises together with the last SCK rise of a data byte.
    task automatic test_cs_race();
        got_q.delete(); exp_q.delete();
        tx_q = '{8'h90, 8'h6B};
        model_write();
        cs_n = 1'b0;
        clk_wait(8);
        spi_byte(8'h90);
        for (int i = 7; i >= 1; i--) begin
            mosi = tx_q[1][i];
            clk_wait(8);
            sck = 1'b1;
            clk_wait(8);
            sck = 1'b0;
        end
        mosi = tx_q[1][0];
        clk_wait(8);
        sck  = 1'b1;
        cs_n = 1'b1;
        clk_wait(8);
        sck = 1'b0;
        clk_wait(8);
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL race_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL race_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (hold !== 1'b0) $display("FAIL race_hold got %b want 0", hold); else n_pass++;
    endtask

    task automatic test_read();
        logic [7:0] exp_b;
        int         r;
        for (int i = 0; i < 32; i++) grid_mem[i] = 8'(i);
        got_q.delete();
        miso_seen = 1'b0;
        tx_q = '{8'h03, 8'h00, 8'h00};
        spi_txn();
`ifdef SILIFE_LOADER_READBACK_EN
        for (int k = 0; k < 2; k++) begin
            exp_b = 8'(3 + k);
            n_total++;
            if (rx_q[k+1] !== exp_b)
                $display("FAIL read_byte[%0d] got %h want %h", k, rx_q[k+1], exp_b);
            else n_pass++;
        end
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 32; i++) grid_mem[i] = 8'($urandom);
            r = int'($urandom_range(0, 31));
            tx_q.delete();
            tx_q.push_back(8'(r) | (8'($urandom_range(0, 3)) << 5));
            for (int b = 0; b < 3; b++) tx_q.push_back(8'($urandom));
            spi_txn();
            for (int k = 0; k < 3; k++) begin
                exp_b = grid_mem[(r + k) % 32];
                n_total++;
                if (rx_q[k+1] !== exp_b)
                    $display("FAIL rand_read[%0d][%0d] got %h want %h", t, k, rx_q[k+1], exp_b);
                else n_pass++;
            end
            n_total++;
            if (row_sel !== 5'((r + 3) % 32))
                $display("FAIL rand_read_row[%0d] got %0d want %0d", t, row_sel, (r + 3) % 32);
            else n_pass++;
        end
`else
        r = 0;
        exp_b = 8'h00;
        n_total++;
        if ({rx_q[1], rx_q[2]} !== {exp_b, exp_b} || miso_seen !== 1'b0)
            $display("FAIL read_miso_zero got %h%h seen %b want 0", rx_q[1], rx_q[2], miso_seen);
        else n_pass++;
        n_total++;
        if (row_sel !== 5'(5 + r)) $display("FAIL read_row got %0d want 5", row_sel); else n_pass++;
`endif
        n_total++;
        if (got_q.size() !== 0) $display("FAIL read_strobe got %0d want 0", got_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midbyte();
        got_q.delete(); exp_q.delete();
        rx_q.delete();
        cs_n = 1'b0;
        clk_wait(8);
        spi_byte(8'h84);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            clk_wait(8);
            sck = 1'b1;
            clk_wait(8);
            sck = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({row_sel, set_c, clr_c, miso, hold} !== 23'h0)
            $display("FAIL midbyte_reset got %h want 0", {row_sel, set_c, clr_c, miso, hold});
        else n_pass++;
        cs_n = 1'b1;
        clk_wait(4);
        rst_n = 1'b1;
        clk_wait(6);
        n_total++;
        if (got_q.size() !== 0) $display("FAIL midbyte_strobe got %0d want 0", got_q.size()); else n_pass++;
        tx_q = '{8'h80, 8'hFF};
        model_write();
        spi_txn();
        n_total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL after_reset_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL after_reset_strobe[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) grid_mem[i] = 8'h00;
        test_reset();
        test_write_single();
        test_write_wrap();
        test_abort();
        test_random_writes();
        test_cs_race();
        test_read();
        test_reset_midbyte();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
